// File: rtl/zx_video_gen_pkg.sv
// Shared types, palettes and address helpers for the ZX Spectrum / Timex pixel generator.
package zx_video_pkg;

    localparam int VRAM_AW = 14;

    typedef enum logic [1:0] {
        MODE_STD   = 2'd0,
        MODE_HICOL = 2'd1,
        MODE_HIRES = 2'd2
    } mode_t;

    typedef enum logic {
        INT_IDLE   = 1'b0,
        INT_ACTIVE = 1'b1
    } int_state_t;

    localparam int ATTR_INK_LSB   = 0;
    localparam int ATTR_PAPER_LSB = 3;
    localparam int ATTR_BRIGHT    = 6;
    localparam int ATTR_FLASH     = 7;

    // Index = {bright, G, R, B}; packed 24-bit colour = {R, G, B}.
    localparam logic [23:0] PALETTE_STD [16] = '{
        24'h000000, 24'h00007F, 24'h7F0000, 24'h7F007F,
        24'h007F00, 24'h007F7F, 24'h7F7F00, 24'h7F7F7F,
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    localparam logic [23:0] PALETTE_ALT [16] = '{
        24'h000000, 24'h0000AA, 24'hAA0000, 24'hAA00AA,
        24'h00AA00, 24'h00AAAA, 24'hAA5500, 24'hAAAAAA,
        24'h555555, 24'h5555FF, 24'hFF5555, 24'hFF55FF,
        24'h55FF55, 24'h55FFFF, 24'hFFFF55, 24'hFFFFFF
    };

    // Spectrum bitmap layout: third, line-in-char, char-row, column.
    function automatic logic [12:0] bmp_offset(input logic [7:0] row, input logic [4:0] col);
        return {row[7:6], row[2:0], row[5:3], col};
    endfunction

    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_HICOL;
            2'd2:    return MODE_HIRES;
            default: return MODE_STD;
        endcase
    endfunction

endpackage

// File: rtl/zx_video_gen_if.sv
// Video RAM read port between the pixel generator (master) and the dual-bank RAM (slave).
interface zx_video_gen_if;
    import zx_video_pkg::*;

    logic [VRAM_AW-1:0] vram_address;
    logic [7:0]         vram_data;

    modport master (output vram_address, input  vram_data);
    modport slave  (input  vram_address, output vram_data);
endinterface

// File: rtl/zx_video_gen_palette.sv
// Colour index to 24-bit RGB, with a switchable alternate palette.
module zx_palette
    import zx_video_pkg::*;
(
    input  logic [3:0]  index_i,
    input  logic        alternate_i,
    output logic [23:0] rgb_o
);

    always_comb begin
        rgb_o = alternate_i ? PALETTE_ALT[index_i] : PALETTE_STD[index_i];
    end

endmodule

// File: rtl/zx_video_gen.sv
// ZX Spectrum / Timex pixel generator: raster-driven VRAM fetch, attribute decode,
// FLASH timing, frame interrupt and registered RGB output.
module zx_video_gen
    import zx_video_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int SCREEN_X0    = 64,
    parameter int SCREEN_Y0    = 48,
    parameter int FLASH_FRAMES = 16,
    parameter int INT_LEN      = 128,
    parameter int PIPE_LAT     = 1
) (
    input  logic            clk_pix,
    input  logic            reset,
    input  logic [9:0]      cx,
    input  logic [9:0]      cy,
    input  logic [1:0]      mode,
    input  logic [2:0]      hires_ink,
    input  logic            alternate_colors,
    input  logic [2:0]      border,
    zx_video_gen_if.master  vram,
    output logic            vs_nintr,
    output logic [23:0]     rgb,
    output logic            flash_phase
);

    localparam int              FC_W     = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FLASH_FRAMES - 1);
    localparam logic [9:0]      FETCH_X0 = 10'(SCREEN_X0 - 16);
    localparam logic [9:0]      PAPER_X0 = 10'(SCREEN_X0);
    localparam logic [9:0]      PAPER_X1 = 10'(SCREEN_X0 + 512);
    localparam logic [9:0]      PAPER_Y0 = 10'(SCREEN_Y0);
    localparam logic [9:0]      ACT_X    = 10'(H_ACTIVE);
    localparam logic [9:0]      ACT_Y    = 10'(V_ACTIVE);
    localparam logic [9:0]      INT_LAST = 10'(INT_LEN - 1);

    logic        frame_start;
    logic        in_rows;
    logic        in_fetch;
    logic        in_paper;
    logic        in_active;
    logic [9:0]  xd;
    logic [9:0]  yd;
    logic [3:0]  tick;
    logic [4:0]  col;
    logic [7:0]  row;
    logic [12:0] bmp;

    mode_t             mode_q, mode_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic              flash_q, flash_d;
    int_state_t        int_state_q, int_state_d;
    logic [9:0]        int_cnt_q, int_cnt_d;
    logic [13:0]       addr_q, addr_d;
    logic [7:0]        pf0_q, pf0_d;
    logic [7:0]        pf1_q, pf1_d;
    logic [7:0]        bits0_q, bits0_d;
    logic [7:0]        bits1_q, bits1_d;

    logic [2:0]  sub_std;
    logic [2:0]  sub_hr;
    logic        pix_on;
    logic [3:0]  color_idx;
    logic [23:0] pal_rgb;

    assign frame_start = (cx == 10'd0) && (cy == 10'd0);
    assign xd          = cx - FETCH_X0;
    assign yd          = cy - PAPER_Y0;
    assign tick        = xd[3:0];
    assign col         = xd[8:4];
    assign row         = yd[8:1];
    assign bmp         = bmp_offset(row, col);

    assign in_rows   = (cy >= PAPER_Y0) && (yd < 10'd384);
    // Fetch span leads the paper window by one 16-clock cell.
    assign in_fetch  = in_rows && (cx >= FETCH_X0) && (xd < 10'd512);
    assign in_paper  = in_rows && (cx >= PAPER_X0) && (cx < PAPER_X1);
    assign in_active = (cx < ACT_X) && (cy < ACT_Y);

    always_comb begin
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        flash_d     = flash_q;
        if (frame_start) begin
            mode_d = decode_mode(mode);
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d = '0;
                flash_d     = ~flash_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end
    end

    // Interrupt width is counted in clocks, so it does not depend on the raster reaching any cx.
    always_comb begin
        int_state_d = int_state_q;
        int_cnt_d   = int_cnt_q;
        case (int_state_q)
            INT_IDLE: begin
                if (frame_start) begin
                    int_state_d = INT_ACTIVE;
                    int_cnt_d   = INT_LAST;
                end
            end
            INT_ACTIVE: begin
                if (frame_start) begin
                    int_cnt_d = INT_LAST;
                end else if (int_cnt_q == 10'd0) begin
                    int_state_d = INT_IDLE;
                end else begin
                    int_cnt_d = int_cnt_q - 10'd1;
                end
            end
            default: int_state_d = INT_IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        pf0_d   = pf0_q;
        pf1_d   = pf1_q;
        bits0_d = bits0_q;
        bits1_d = bits1_q;
        if (in_fetch) begin
            case (tick)
                4'd8:  addr_d = {1'b0, bmp};
                4'd10: begin
                    pf0_d  = vram.vram_data;
                    addr_d = (mode_q == MODE_STD) ? {1'b0, 3'b110, row[7:3], col}
                                                  : {1'b1, bmp};
                end
                4'd12: pf1_d = vram.vram_data;
                4'd15: begin
                    bits0_d = pf0_q;
                    bits1_d = pf1_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sub_std   = ~cx[3:1];
        sub_hr    = ~cx[2:0];
        pix_on    = 1'b0;
        color_idx = 4'd0;
        if (mode_q == MODE_HIRES) begin
            pix_on = cx[3] ? bits1_q[sub_hr] : bits0_q[sub_hr];
        end else begin
            pix_on = bits0_q[sub_std] ^ (bits1_q[ATTR_FLASH] & flash_q);
        end

        if (!in_active) begin
            color_idx = 4'd0;
        end else if (in_paper) begin
            if (mode_q == MODE_HIRES) begin
                color_idx = {1'b1, pix_on ? hires_ink : ~hires_ink};
            end else begin
                color_idx = {bits1_q[ATTR_BRIGHT],
                             pix_on ? bits1_q[ATTR_INK_LSB +: 3] : bits1_q[ATTR_PAPER_LSB +: 3]};
            end
        end else begin
            color_idx = (mode_q == MODE_HIRES) ? {1'b1, ~hires_ink} : {1'b0, border};
        end
    end

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            mode_q      <= MODE_STD;
            frame_cnt_q <= '0;
            flash_q     <= 1'b0;
            int_state_q <= INT_IDLE;
            int_cnt_q   <= '0;
            addr_q      <= '0;
            pf0_q       <= '0;
            pf1_q       <= '0;
            bits0_q     <= '0;
            bits1_q     <= '0;
        end else begin
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            flash_q     <= flash_d;
            int_state_q <= int_state_d;
            int_cnt_q   <= int_cnt_d;
            addr_q      <= addr_d;
            pf0_q       <= pf0_d;
            pf1_q       <= pf1_d;
            bits0_q     <= bits0_d;
            bits1_q     <= bits1_d;
        end
    end

    zx_palette u_palette (
        .index_i     (color_idx),
        .alternate_i (alternate_colors),
        .rgb_o       (pal_rgb)
    );

    for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_rgb_pipe
        logic [23:0] stage_q;
        if (gi == 0) begin : g_head
            always_ff @(posedge clk_pix) begin
                if (reset) stage_q <= '0;
                else       stage_q <= pal_rgb;
            end
        end else begin : g_tail
            always_ff @(posedge clk_pix) begin
                if (reset) stage_q <= '0;
                else       stage_q <= g_rgb_pipe[gi-1].stage_q;
            end
        end
    end

    assign rgb               = g_rgb_pipe[PIPE_LAT-1].stage_q;
    assign vram.vram_address = addr_q;
    assign vs_nintr          = (int_state_q == INT_IDLE);
    assign flash_phase       = flash_q;

endmodule

// File: tb/tb_zx_video_gen.sv
// Directed bench: drives cx/cy directly, models the VRAM with a registered read, checks rgb/address/interrupt.
module tb_zx_video_gen;

    logic        clk_pix = 1'b0;
    logic        reset   = 1'b1;
    logic [9:0]  cx = '0;
    logic [9:0]  cy = '0;
    logic [1:0]  mode = '0;
    logic [2:0]  hires_ink = '0;
    logic        alternate_colors = 1'b0;
    logic [2:0]  border = 3'd2;
    logic        vs_nintr;
    logic [23:0] rgb;
    logic        flash_phase;

    zx_video_gen_if vif();

    zx_video_gen dut (
        .clk_pix          (clk_pix),
        .reset            (reset),
        .cx               (cx),
        .cy               (cy),
        .mode             (mode),
        .hires_ink        (hires_ink),
        .alternate_colors (alternate_colors),
        .border           (border),
        .vram             (vif),
        .vs_nintr         (vs_nintr),
        .rgb              (rgb),
        .flash_phase      (flash_phase)
    );

    always #5 clk_pix = ~clk_pix;

    logic [7:0] mem [0:16383];
    always_ff @(posedge clk_pix) vif.vram_data <= mem[vif.vram_address];

    typedef struct {
        int          scen;
        int          x;
        logic [23:0] exp;
    } pix_vec_t;

    localparam int NV = 24;
    pix_vec_t    vecs [NV];
    logic [23:0] cap [0:8][0:639];
    logic [13:0] addr_cap [0:639];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("PASS %s: %h", name, act);
        end
    endtask

    task automatic step(input int x, input int y);
        cx = 10'(x);
        cy = 10'(y);
        @(posedge clk_pix);
        #1;
    endtask

    task automatic scan(input int s, input int y);
        for (int x = 0; x < 640; x++) begin
            step(x, y);
            cap[s][x]   = rgb;
            addr_cap[x] = vif.vram_address;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(5, 5);
        step(5, 5);
        reset = 1'b0;
    endtask

    initial begin
        int low;

        vecs[0]  = '{0, 64,  24'hFFFFFF};
        vecs[1]  = '{0, 65,  24'hFFFFFF};
        vecs[2]  = '{0, 66,  24'h000000};
        vecs[3]  = '{0, 10,  24'h7F0000};
        vecs[4]  = '{0, 600, 24'h7F0000};
        vecs[5]  = '{0, 80,  24'h00007F};
        vecs[6]  = '{0, 88,  24'h7F0000};
        vecs[7]  = '{1, 64,  24'h000000};
        vecs[8]  = '{1, 66,  24'h7F7F7F};
        vecs[9]  = '{2, 64,  24'h7F7F7F};
        vecs[10] = '{2, 66,  24'h000000};
        vecs[11] = '{3, 64,  24'h0000FF};
        vecs[12] = '{3, 71,  24'h0000FF};
        vecs[13] = '{3, 72,  24'hFFFF00};
        vecs[14] = '{3, 79,  24'hFFFF00};
        vecs[15] = '{3, 10,  24'hFFFF00};
        vecs[16] = '{4, 64,  24'h007F7F};
        vecs[17] = '{5, 64,  24'hFF0000};
        vecs[18] = '{5, 72,  24'h000000};
        vecs[19] = '{6, 64,  24'hFF0000};
        vecs[20] = '{7, 64,  24'h7F0000};
        vecs[21] = '{7, 10,  24'h7F0000};
        vecs[22] = '{8, 64,  24'h0000FF};
        vecs[23] = '{8, 10,  24'hFFFF00};

        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;

        // Standard mode
        do_reset();
        mem[14'h0000] = 8'h80;
        mem[14'h1800] = 8'h47;
        mem[14'h0001] = 8'h0F;
        mem[14'h1801] = 8'h0A;
        mode = 2'd0;
        step(0, 0);
        scan(0, 48);
        chk("addr_tick8_col0",   32'(addr_cap[56]),  32'h0000);
        chk("addr_tick10_col0",  32'(addr_cap[58]),  32'h1800);
        chk("addr_tick8_col1",   32'(addr_cap[72]),  32'h0001);
        chk("addr_tick10_col1",  32'(addr_cap[74]),  32'h1801);
        chk("addr_hold_outside", 32'(addr_cap[639]), 32'h181F);
        step(700, 48);
        chk("outside_active_x", 32'(rgb), 32'h000000);
        step(10, 48);
        step(100, 500);
        chk("outside_active_y", 32'(rgb), 32'h000000);

        // FLASH timing
        do_reset();
        mem[14'h1800] = 8'hB8;
        for (int f = 0; f < 15; f++) step(0, 0);
        chk("flash_after_15", 32'(flash_phase), 32'd0);
        scan(1, 48);
        step(0, 0);
        chk("flash_after_16", 32'(flash_phase), 32'd1);
        scan(2, 48);

        // Hi-res
        mem[14'h0000] = 8'hFF;
        mem[14'h2000] = 8'h00;
        hires_ink = 3'd1;
        mode = 2'd2;
        step(0, 0);
        scan(3, 48);
        chk("hires_addr_bank1", 32'(addr_cap[58]), 32'h2000);

        // Hi-colour
        mem[14'h2000] = 8'h0D;
        mem[14'h0100] = 8'hF0;
        mem[14'h2100] = 8'h42;
        mode = 2'd1;
        step(0, 0);
        scan(4, 48);
        scan(5, 50);
        scan(6, 51);

        // Mode change mid-frame takes effect at the next frame start
        mem[14'h1800] = 8'h0A;
        mode = 2'd0;
        step(0, 0);
        mode = 2'd2;
        scan(7, 48);
        step(0, 0);
        scan(8, 48);

        // Reserved mode and alternate palette
        mode = 2'd3;
        step(0, 0);
        step(10, 48);
        chk("mode3_as_std_border", 32'(rgb), 32'h7F0000);
        alternate_colors = 1'b1;
        step(10, 48);
        chk("alt_palette_border", 32'(rgb), 32'hAA0000);
        alternate_colors = 1'b0;

        for (int i = 0; i < NV; i++) begin
            chk($sformatf("pix_s%0d_cx%0d", vecs[i].scen, vecs[i].x),
                32'(cap[vecs[i].scen][vecs[i].x]), 32'(vecs[i].exp));
        end

        // Interrupt width and reset behaviour
        mode = 2'd0;
        do_reset();
        chk("reset_vs_nintr", 32'(vs_nintr), 32'd1);
        chk("reset_rgb",      32'(rgb), 32'h000000);
        chk("reset_addr",     32'(vif.vram_address), 32'h0000);
        chk("reset_flash",    32'(flash_phase), 32'd0);
        step(0, 0);
        low = (vs_nintr == 1'b0) ? 1 : 0;
        for (int i = 1; i < 1000 && vs_nintr == 1'b0; i++) begin
            step(i, 0);
            if (vs_nintr == 1'b0) low++;
        end
        chk("int_low_clocks", 32'(low), 32'd128);

        step(0, 0);
        for (int i = 1; i < 39; i++) step(i, 0);
        chk("int_low_at_39", 32'(vs_nintr), 32'd0);
        chk("border_at_39",  32'(rgb), 32'h7F0000);
        reset = 1'b1;
        step(39, 0);
        chk("reset_mid_pulse_vs",  32'(vs_nintr), 32'd1);
        chk("reset_mid_pulse_rgb", 32'(rgb), 32'h000000);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zx_video_gen.md
Name: zx_video_gen

Overview:
- Parametrised ZX Spectrum / Timex-compatible pixel generator. Replaces the fixed 256x192 line-doubled video path.
- Consumes the HDMI core's cx/cy raster counters and fetches bitmap/attribute bytes from dual-bank video RAM.
- Produces registered 24-bit RGB for the HDMI core plus the Z80 frame interrupt.
- Adds Timex hi-colour (8x1 attributes) and hi-res (512x192) modes, a true per-frame FLASH counter, and a configurable interrupt pulse.

Parameters:
H_ACTIVE, 640, visible raster width in clocks
V_ACTIVE, 480, visible raster height in lines
SCREEN_X0, 64, first cx of the 512-clock paper window
SCREEN_Y0, 48, first cy of the 384-line paper window
FLASH_FRAMES, 16, frames per FLASH phase
INT_LEN, 128, vs_nintr low width in clk_pix cycles (1..1023)
PIPE_LAT, 1, rgb latency vs cx (fixed at 1; integrator compensates)

Ports:
clk_pix  in  1  pixel clock
reset  in  1  synchronous, active-high
cx  in  10  horizontal raster counter from the HDMI core
cy  in  10  vertical raster counter from the HDMI core
mode  in  2  0=standard, 1=hi-colour, 2=hi-res, 3=reserved (treated as 0)
hires_ink  in  3  ink index in hi-res mode
alternate_colors  in  1  selects the alternate palette
border  in  3  border colour index
vram_address  out  14  bit13 = bank select, bits 12:0 = Spectrum offset
vram_data  in  8  read data, valid 2 clocks after the address is driven
vs_nintr  out  1  active-low frame interrupt
rgb  out  24  pixel colour
flash_phase  out  1  current FLASH inversion state

Behaviour:
- Reset values: rgb=0, vram_address=0, vs_nintr=1, flash_phase=0, frame counter=0, latched mode=0, all fetch and working registers=0.
- frame_start = (cx==0 && cy==0).
- The latched mode updates only at frame_start, so no mid-frame mode tearing. Value 3 latches as 0.
- Frame counter (width clog2(FLASH_FRAMES)):
  - increments at frame_start;
  - on reaching FLASH_FRAMES-1 it wraps to 0 and toggles flash_phase.
- vs_nintr:
  - goes low on the clock after frame_start and stays low for exactly INT_LEN clocks;
  - a counter enforces the width, independent of cx;
  - if reset asserts mid-pulse, vs_nintr returns to 1 on the next clock.
- Coordinates:
  - xd = cx-(SCREEN_X0-16); tick = xd[3:0]; col = xd[8:4];
  - yd = cy-SCREEN_Y0; row = yd[8:1].
- Bitmap offset: bmp = {row[7:6], row[2:0], row[5:3], col}.
- Fetch schedule per 16-clock cell (cell N is fetched during the 16 clocks before it is displayed):
  - tick 8: drive address {0, bmp}.
  - tick 10: sample vram_data into pf0. In the same clock, drive the second address:
    - standard: {0, 3'b110, row[7:3], col};
    - hi-colour and hi-res: {1, bmp}.
  - tick 12: sample vram_data into pf1.
  - tick 15: bits0<=pf0; bits1<=pf1.
- Pixel selection:
  - standard / hi-colour: pixbit = bits0[7-cx[3:1]]. Each Spectrum pixel spans 2 clocks and 2 lines.
  - hi-res: pixbit = cx[3] ? bits1[7-cx[2:0]] : bits0[7-cx[2:0]]. One pixel per clock.
- Attribute decoding:
  - standard / hi-colour: attribute = bits1; inverted = attr[7] & flash_phase.
  - hi-res: ink = hires_ink, paper = ~hires_ink, bright=1, no flash.
- Colour index:
  - inside paper window: bright, then ink or paper;
  - outside the window but inside the active area: {0, border}; in hi-res, the border uses the paper index with bright=1;
  - outside the active area: index forced to black.
- rgb is registered from the palette lookup; latency 1 clock from cx.
- No addresses are issued outside the paper window's fetch span. vram_address holds its last value there.

Decomposition:
- Package zx_video_pkg:
  - mode_t enum (MODE_STD, MODE_HICOL, MODE_HIRES);
  - two 16x24-bit palette constant arrays (standard, alternate);
  - attribute field bit positions;
  - bmp_offset() swizzle function.
- Sub-module zx_palette: combinational index plus alternate_colors to 24-bit RGB.
- Top contains counters, fetch FSM, pixel mux and output register.

Test Plan:
- Standard mode, bitmap byte 0x80 at offset 0, attr 0x47 at 0x1800 -> cx=64..65, cy=48: rgb=FFFFFF one clock later; cx=66: rgb=000000. vram_address = 0x0000 at tick 8, then 0x1800 at tick 10.
- Flash, attr 0xB8, FLASH_FRAMES=16 -> flash_phase toggles after the 16th frame_start; ink/paper swap (0x7F7F7F <-> 0x000000) exactly at the toggle.
- Hi-res, bank0 byte 0xFF, bank1 byte 0x00, hires_ink=1 -> 8 clocks of 0x0000FF, then 8 clocks of 0xFFFF00; border = 0xFFFF00.
- Hi-colour, bank1 offset 0x0100 (row 1) = 0x42 -> line pair cy=50..51 uses bright red ink; cy=48..49 uses bank1 offset 0x0000 attr.
- Interrupt, INT_LEN=128 -> vs_nintr low for exactly 128 clocks after frame_start. Reset at clock 40 -> vs_nintr=1 next clock, rgb=0.
- mode switched 0->2 mid-frame -> output stays standard until the next frame_start, then becomes hi-res.
